hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/hazard_ctl.sv | 137 +++++++++++++
 tb/tb_hazard_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: forwarding select, load-use stall,
// taken-branch flush sequencing and saturating event counters.
module hazard_ctl #(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [4:0]       memwb_rd,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  localparam logic [3:0] FC_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic       MULTI   = (FLUSH_CYCLES > 1);

  logic       taken;
  logic       load_use;
  logic [1:0] eff;
  logic [1:0] nxt;
  logic [3:0] flush_left;
  logic [3:0] nxt_left;

  assign taken    = exmem_branch & exmem_zero;
  assign load_use = id_valid & idex_memread & (idex_rt != 5'd0) &
                    ((idex_rt == id_rs) | (idex_rt == id_rt));

  // During reset the outputs decode as if in RUN
  assign eff = rst ? RUN : state;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       xw,
    input logic [4:0] xrd,
    input logic       ww,
    input logic [4:0] wrd
  );
    if (xw && xrd != 5'd0 && xrd == src)
      return 2'b10;
    else if (ww && wrd != 5'd0 && wrd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Operand forwarding, newer EX/MEM result wins
  always_comb begin
    fwd_a = fwd_sel(idex_rs, exmem_regwrite, exmem_rd,
                    memwb_regwrite, memwb_rd);
    fwd_b = fwd_sel(idex_rt, exmem_regwrite, exmem_rd,
                    memwb_regwrite, memwb_rd);
  end

  // Control decode and next-state logic
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    pc_src      = 1'b0;
    nxt         = RUN;
    nxt_left    = flush_left;
    case (eff)
      FLUSH: begin
        flush = 1'b1;
        if (flush_left <= 4'd1) begin
          nxt = RUN;
        end else begin
          nxt      = FLUSH;
          nxt_left = flush_left - 4'd1;
        end
      end
      STALL: begin
        if (taken) begin
          flush    = 1'b1;
          pc_src   = 1'b1;
          nxt      = MULTI ? FLUSH : RUN;
          nxt_left = FC_LOAD;
        end
      end
      default: begin
        if (taken) begin
          flush    = 1'b1;
          pc_src   = 1'b1;
          nxt      = MULTI ? FLUSH : RUN;
          nxt_left = FC_LOAD;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          nxt         = STALL;
        end
      end
    endcase
  end

  // State, flush countdown and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= 4'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= nxt;
      flush_left <= nxt_left;
      if (idex_bubble && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pc_src && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed-vector scoreboard bench for hazard_ctl
// (CNT_W=2, FLUSH_CYCLES=3).
module tb_hazard_ctl;

  typedef struct packed {
    logic       rst;
    logic       idv;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       mr;
    logic       xw;
    logic       ww;
    logic [4:0] xrd;
    logic [4:0] wrd;
    logic       br;
    logic       z;
  } stim_t;

  typedef struct packed {
    logic       pw;
    logic       iw;
    logic       bub;
    logic       fl;
    logic       ps;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
    logic [1:0] sc;
    logic [1:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, idex_rs, idex_rt;
  logic       idex_memread;
  logic       exmem_regwrite, memwb_regwrite;
  logic [4:0] exmem_rd, memwb_rd;
  logic       exmem_branch, exmem_zero;
  logic       pc_write, ifid_write, idex_bubble, flush, pc_src;
  logic [1:0] fwd_a, fwd_b, state;
  logic [1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int   applied = 0;
  int   miss    = 0;

  always #5 clk = ~clk;

  hazard_ctl #(.CNT_W(2), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite),
    .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .flush(flush), .pc_src(pc_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t lu(input stim_t b);
    stim_t s;
    s       = b;
    s.idv   = 1'b1;
    s.mr    = 1'b1;
    s.ex_rt = 5'd3;
    s.id_rs = 5'd3;
    return s;
  endfunction

  function automatic stim_t tk(input stim_t b);
    stim_t s;
    s    = b;
    s.br = 1'b1;
    s.z  = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(
    input logic pw, iw, bub, fl, ps,
    input logic [1:0] fa, fb, st, sc, fc
  );
    exp_t e;
    e = {pw, iw, bub, fl, ps, fa, fb, st, sc, fc};
    return e;
  endfunction

  task automatic put(input stim_t s);
    rst            = s.rst;
    id_valid       = s.idv;
    id_rs          = s.id_rs;
    id_rt          = s.id_rt;
    idex_rs        = s.ex_rs;
    idex_rt        = s.ex_rt;
    idex_memread   = s.mr;
    exmem_regwrite = s.xw;
    memwb_regwrite = s.ww;
    exmem_rd       = s.xrd;
    memwb_rd       = s.wrd;
    exmem_branch   = s.br;
    exmem_zero     = s.z;
  endtask

  task automatic drive(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    put(s);
    q.push_back(e);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t w;
      exp_t a;
      w = q.pop_front();
      a = {pc_write, ifid_write, idex_bubble, flush, pc_src,
           fwd_a, fwd_b, state, stall_cnt, flush_cnt};
      applied++;
      if (a !== w) begin
        miss++;
        $display("FAIL vec%0d got pw%b iw%b bub%b fl%b ps%b fa%b fb%b st%b sc%0d fc%0d want pw%b iw%b bub%b fl%b ps%b fa%b fb%b st%b sc%0d fc%0d",
          applied, a.pw, a.iw, a.bub, a.fl, a.ps, a.fa, a.fb, a.st,
          a.sc, a.fc, w.pw, w.iw, w.bub, w.fl, w.ps, w.fa, w.fb,
          w.st, w.sc, w.fc);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    put(s);
    repeat (2) @(posedge clk);

    // reset cycles decode as RUN, no counting
    drive(s, ex(1,1,0,0,0,0,0,0,0,0));
    drive(lu(s), ex(0,0,1,0,0,0,0,0,0,0));
    drive(tk(s), ex(1,1,0,1,1,0,0,0,0,0));
    drive(s, ex(1,1,0,0,0,0,0,0,0,0));

    // forwarding priority
    s = idle();
    s.ex_rs = 5'd5; s.xrd = 5'd5; s.wrd = 5'd5;
    s.xw = 1'b1; s.ww = 1'b1;
    drive(s, ex(1,1,0,0,0,2'b10,0,0,0,0));
    s.xw = 1'b0;
    drive(s, ex(1,1,0,0,0,2'b01,0,0,0,0));
    s.xw = 1'b1; s.xrd = 5'd0; s.wrd = 5'd0;
    drive(s, ex(1,1,0,0,0,2'b00,0,0,0,0));
    s = idle();
    s.ex_rs = 5'd9; s.ex_rt = 5'd7; s.xrd = 5'd7; s.wrd = 5'd7;
    s.xw = 1'b1; s.ww = 1'b1;
    drive(s, ex(1,1,0,0,0,2'b00,2'b10,0,0,0));

    // load-use stall
    drive(lu(idle()), ex(0,0,1,0,0,0,0,0,0,0));
    drive(lu(idle()), ex(1,1,0,0,0,0,0,1,1,0));
    drive(idle(), ex(1,1,0,0,0,0,0,0,1,0));
    s = lu(idle()); s.ex_rt = 5'd0; s.id_rs = 5'd0;
    drive(s, ex(1,1,0,0,0,0,0,0,1,0));
    s = lu(idle()); s.idv = 1'b0;
    drive(s, ex(1,1,0,0,0,0,0,0,1,0));

    // branch, 3 flush cycles; FLUSH ignores taken/load-use
    drive(tk(idle()), ex(1,1,0,1,1,0,0,0,1,0));
    drive(tk(lu(idle())), ex(1,1,0,1,0,0,0,2,1,1));
    drive(idle(), ex(1,1,0,1,0,0,0,2,1,1));
    drive(idle(), ex(1,1,0,0,0,0,0,0,1,1));

    // simultaneous branch and load-use: branch wins
    drive(tk(lu(idle())), ex(1,1,0,1,1,0,0,0,1,1));
    drive(idle(), ex(1,1,0,1,0,0,0,2,1,2));
    drive(idle(), ex(1,1,0,1,0,0,0,2,1,2));
    drive(idle(), ex(1,1,0,0,0,0,0,0,1,2));

    // taken branch while in STALL
    drive(lu(idle()), ex(0,0,1,0,0,0,0,0,1,2));
    drive(tk(idle()), ex(1,1,0,1,1,0,0,1,2,2));
    drive(idle(), ex(1,1,0,1,0,0,0,2,2,3));
    drive(idle(), ex(1,1,0,1,0,0,0,2,2,3));
    drive(idle(), ex(1,1,0,0,0,0,0,0,2,3));

    // stall counter saturation
    for (int i = 0; i < 5; i++) begin
      logic [1:0] sc;
      sc = (i == 0) ? 2'd2 : 2'd3;
      drive(lu(idle()), ex(0,0,1,0,0,0,0,0,sc,3));
      drive(idle(), ex(1,1,0,0,0,0,0,1,3,3));
    end
    drive(idle(), ex(1,1,0,0,0,0,0,0,3,3));

    // flush counter saturation, then reset aborts FLUSH
    drive(tk(idle()), ex(1,1,0,1,1,0,0,0,3,3));
    s = idle(); s.rst = 1'b1;
    drive(s, ex(1,1,0,0,0,0,0,2,3,3));
    drive(lu(idle()), ex(0,0,1,0,0,0,0,0,0,0));
    drive(idle(), ex(1,1,0,0,0,0,0,1,1,0));
    drive(idle(), ex(1,1,0,0,0,0,0,0,1,0));

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      miss++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miss);
    $finish;
  end

endmodule
